pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic parametrised pipeline stage register that replaces the fixed-field inter-stage registers (IF/ID … MEM/WB) of the pipelined RISC-V core. It carries an opaque control vector and an opaque data vector with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer that registers the backpressure path. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
CTRL_W, 8, width of control bundle (regwrite, wb select, memread, …); zeroed on reset/flush
DATA_W, 128, width of data bundle (PC, IMM, ALUOUT, MEMDATA, RD, …)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CLEAR_DATA, 1, 1 = data zeroed on reset/flush; 0 = data held (valid/ctrl still cleared)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
flush  in  1  synchronous flush; kills all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  registered control bundle
out_data  out  DATA_W  registered data bundle
occupancy  out  2  entries held (0..2; max 1 when SKID=0)
stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready

Behaviour:
- Reset (rst=0 at posedge): out_valid=0, out_ctrl=0, out_data=0 (held if CLEAR_DATA=0), skid entry invalid, occupancy=0, stall_cnt=0. in_ready is 1 the cycle after reset (SKID=1). Reset mid-transfer discards all entries.
- Handshakes: in-transfer when in_valid & in_ready; out-transfer when out_valid & out_ready. out_ctrl/out_data remain stable while out_valid & !out_ready.
- Latency: 1 cycle from in-transfer to out_valid when the stage is empty. Full throughput: 1 entry/cycle when out_ready=1.
- SKID=0: in_ready = !out_valid | out_ready (combinational). On an in-transfer the register loads the input. On an out-transfer without an in-transfer, out_valid falls to 0.
- SKID=1: main reg (drives outputs) plus skid reg; in_ready = !skid_valid (registered).
  - EMPTY (occ 0): an in-transfer loads main -> ONE.
  - ONE: an in- and out-transfer together load main (stay ONE). An in-transfer alone loads skid -> FULL. An out-transfer alone -> EMPTY.
  - FULL (occ 2, in_ready=0): an out-transfer moves skid to main -> ONE. Otherwise hold.
- Order is preserved: skid content is always younger than main.
- Flush: has priority over every transfer. At the edge, main and skid are invalidated, ctrl is zeroed (data is zeroed only if CLEAR_DATA=1) and occ=0. An input presented in the flush cycle is dropped, even though a handshake completed. An out-transfer in that cycle is still a valid consumption downstream.
- Simultaneous rst=0 and flush: reset behaviour.
- stall_cnt: increments by 1 per cycle where out_valid & !out_ready and saturates at 2^CNT_W-1. It is cleared only by reset, not by flush.
- No X propagation: ctrl of an invalid entry is always 0.

Decomposition:
- Package pipe_pkg: constants for default CTRL_W/DATA_W per stage boundary, and a packed-struct typedef per boundary (e.g. mem_wb_ctrl_t: regwrite, datatoregsel[2:0], memread). Callers cast their struct to in_ctrl/in_data.
- No sub-module required. The skid path is a generate branch, and the stall counter is inline.

Test Plan:
- Reset: drive rst=0 with in_valid=1, in_ctrl=8'hFF, in_data=128'h1234 for 2 cycles, then release -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1, send ctrl=1..10, data=100..109 on consecutive cycles -> each appears exactly 1 cycle later, in order, with no bubbles.
- Backpressure (SKID=1): hold out_ready=0, send A=5, B=6, C=7 -> A is on outputs, B is in skid, occupancy=2, in_ready=0, C is held upstream. Release out_ready -> the output sequence is A, B, C and nothing is lost or duplicated.
- Flush: with occupancy=2, assert flush while in_valid=1 (ctrl=8'h3C) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 8'h3C never appears.
- Stall counter: CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15. A subsequent flush leaves it at 15; reset clears it to 0.
- SKID=0 path: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally, and a new entry replaces the old one at the edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and per-boundary control bundle layouts for pipe_stage_reg users
package pipe_pkg;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DATA_W = 128;
  localparam int IF_ID_DATA_W = 64;
  localparam int ID_EX_DATA_W = 128;
  localparam int EX_MEM_DATA_W = 104;
  localparam int MEM_WB_DATA_W = 72;
  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic [3:0] aluop;
    logic       regwrite;
  } id_ex_ctrl_t;
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic [2:0] memsize;
    logic       regwrite;
    logic [1:0] datatoregsel;
  } ex_mem_ctrl_t;
  typedef struct packed {
    logic       regwrite;
    logic [2:0] datatoregsel;
    logic       memread;
  } mem_wb_ctrl_t;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline stage register with optional skid buffer, flush and stall counter
// Ports: clk, rst (sync, active-low), flush (sync kill of held entries),
//   in_valid/in_ready/in_ctrl/in_data (upstream), out_valid/out_ready/out_ctrl/out_data (downstream),
//   occupancy (entries held 0..2), stall_cnt (saturating count of out_valid & !out_ready cycles).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic in_xfer, out_xfer, skid_valid;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};
  generate
    if (SKID != 0) begin : g_skid
      logic              sv;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;
      // in_ready comes straight from a flop, breaking the combinational backpressure path
      assign in_ready   = !sv;
      assign skid_valid = sv;
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          out_valid <= 1'b0;
          out_ctrl  <= '0;
          sv        <= 1'b0;
          skid_ctrl <= '0;
          if (CLEAR_DATA != 0) begin
            out_data  <= '0;
            skid_data <= '0;
          end
        end else if (!out_valid || out_xfer) begin
          // main frees up: the older skid entry goes first; in_ready was low so no input arrives then
          if (sv) begin
            out_valid <= 1'b1;
            out_ctrl  <= skid_ctrl;
            out_data  <= skid_data;
            sv        <= 1'b0;
            skid_ctrl <= '0;
          end else begin
            out_valid <= in_xfer;
            out_ctrl  <= in_xfer ? in_ctrl : '0;
            if (in_xfer) out_data <= in_data;
          end
        end else if (in_xfer) begin
          sv        <= 1'b1;
          skid_ctrl <= in_ctrl;
          skid_data <= in_data;
        end
      end
    end else begin : g_single
      assign in_ready   = !out_valid | out_ready;
      assign skid_valid = 1'b0;
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          out_valid <= 1'b0;
          out_ctrl  <= '0;
          if (CLEAR_DATA != 0) out_data <= '0;
        end else if (in_xfer) begin
          out_valid <= 1'b1;
          out_ctrl  <= in_ctrl;
          out_data  <= in_data;
        end else if (out_xfer) begin
          out_valid <= 1'b0;
          out_ctrl  <= '0;
        end
      end
    end
  endgenerate
  // flush deliberately leaves the counter alone so stalls survive pipeline kills
  always_ff @(posedge clk) begin
    if (!rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven check of the skid stage plus hand sequences for saturation and the single-register variant
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]   in_ctrl = '0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [7:0]   out_ctrl;
  logic [127:0] out_data;
  logic [1:0]   occupancy;
  logic [3:0]   stall_cnt;

  logic         rz = 1'b0, fz = 1'b0, ivz = 1'b0, orz = 1'b0;
  logic [7:0]   icz = '0;
  logic [127:0] idz = '0;
  logic         irz, ovz;
  logic [7:0]   ocz;
  logic [127:0] odz;
  logic [1:0]   occz;
  logic [3:0]   stz;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0), .CLEAR_DATA(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rz), .flush(fz), .in_valid(ivz), .in_ready(irz),
    .in_ctrl(icz), .in_data(idz), .out_valid(ovz), .out_ready(orz),
    .out_ctrl(ocz), .out_data(odz), .occupancy(occz), .stall_cnt(stz));

  typedef struct {
    logic        r, f, iv;
    logic [7:0]  ic;
    logic [31:0] id;
    logic        o, eov;
    logic [7:0]  ec;
    logic [31:0] ed;
    logic        cd;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  vec_t tv[$];
  int nvec = 0, nerr = 0;
  logic m_ov = 1'b0;
  logic [3:0] m_st = '0;

  task automatic add(input logic r, f, iv, input logic [7:0] ic, input logic [31:0] id, input logic o,
                     input logic eov, input logic [7:0] ec, input logic [31:0] ed, input logic cd,
                     input logic [1:0] eocc, input logic eir);
    tv.push_back('{r, f, iv, ic, id, o, eov, ec, ed, cd, eocc, eir});
  endtask

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic r, f, iv, input logic [7:0] ic, input logic [31:0] id, input logic o);
    rst = r; flush = f; in_valid = iv; in_ctrl = ic; in_data = {96'b0, id}; out_ready = o;
    if (!r) m_st = '0;
    else if (m_ov && !o && m_st != 4'hF) m_st = m_st + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic r, f, iv, input logic [7:0] ic, input logic o);
    rz = r; fz = f; ivz = iv; icz = ic; idz = {120'b0, ic}; orz = o;
  endtask

  initial begin
    add(0, 0, 1, 8'hFF, 32'h1234, 0,  0, 8'h00, 0, 1, 0, 1);
    add(0, 0, 1, 8'hFF, 32'h1234, 0,  0, 8'h00, 0, 1, 0, 1);
    for (int k = 1; k <= 10; k++)
      add(1, 0, 1, 8'(k), 32'(99 + k), 1,  1, 8'(k), 32'(99 + k), 1, 1, 1);
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 5, 5, 0,  1, 5, 5, 1, 1, 1);
    add(1, 0, 1, 6, 6, 0,  1, 5, 5, 1, 2, 0);
    add(1, 0, 1, 7, 7, 0,  1, 5, 5, 1, 2, 0);
    add(1, 0, 1, 7, 7, 1,  1, 6, 6, 1, 1, 1);
    add(1, 0, 1, 7, 7, 1,  1, 7, 7, 1, 1, 1);
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 11, 11, 0,  1, 11, 11, 1, 1, 1);
    add(1, 0, 1, 12, 12, 0,  1, 11, 11, 1, 2, 0);
    add(1, 1, 1, 8'h3C, 60, 0,  0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(1, 1, 1, 8'h3C, 60, 1,  0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 13, 13, 1,  1, 13, 13, 1, 1, 1);
    add(1, 1, 1, 8'h3C, 60, 1,  0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].r, tv[i].f, tv[i].iv, tv[i].ic, tv[i].id, tv[i].o);
      m_ov = tv[i].eov;
      chk($sformatf("v%0d out_valid", i), {127'b0, out_valid}, {127'b0, tv[i].eov});
      chk($sformatf("v%0d out_ctrl", i), {120'b0, out_ctrl}, {120'b0, tv[i].ec});
      if (tv[i].cd) chk($sformatf("v%0d out_data", i), out_data, {96'b0, tv[i].ed});
      chk($sformatf("v%0d occupancy", i), {126'b0, occupancy}, {126'b0, tv[i].eocc});
      chk($sformatf("v%0d in_ready", i), {127'b0, in_ready}, {127'b0, tv[i].eir});
      chk($sformatf("v%0d stall_cnt", i), {124'b0, stall_cnt}, {124'b0, m_st});
    end

    drive(1, 0, 1, 8'h40, 32'h40, 0);
    m_ov = 1'b1;
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0);
    chk("sat stall_cnt", {124'b0, stall_cnt}, 128'd15);
    chk("sat model", {124'b0, m_st}, 128'd15);
    chk("sat out_ctrl stable", {120'b0, out_ctrl}, 128'h40);
    chk("sat out_data stable", out_data, 128'h40);
    drive(1, 1, 0, 0, 0, 0);
    m_ov = 1'b0;
    chk("flush keeps stall_cnt", {124'b0, stall_cnt}, 128'd15);
    chk("flush out_valid", {127'b0, out_valid}, 128'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("reset clears stall_cnt", {124'b0, stall_cnt}, 128'd0);

    drive0(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("z reset out_valid", {127'b0, ovz}, 128'd0);
    chk("z reset in_ready", {127'b0, irz}, 128'd1);
    drive0(1, 0, 1, 8'd21, 0);
    @(posedge clk); #1;
    chk("z load out_ctrl", {120'b0, ocz}, 128'd21);
    chk("z load occupancy", {126'b0, occz}, 128'd1);
    drive0(1, 0, 0, 0, 0);
    #1;
    chk("z stalled in_ready", {127'b0, irz}, 128'd0);
    drive0(1, 0, 1, 8'd22, 1);
    #1;
    chk("z comb in_ready", {127'b0, irz}, 128'd1);
    @(posedge clk); #1;
    chk("z replace out_ctrl", {120'b0, ocz}, 128'd22);
    chk("z replace out_data", odz, 128'd22);
    chk("z replace out_valid", {127'b0, ovz}, 128'd1);
    drive0(1, 0, 1, 8'd23, 0);
    @(posedge clk); #1;
    chk("z held out_ctrl", {120'b0, ocz}, 128'd22);
    drive0(1, 1, 1, 8'd24, 0);
    @(posedge clk); #1;
    chk("z flush out_valid", {127'b0, ovz}, 128'd0);
    chk("z flush out_ctrl", {120'b0, ocz}, 128'd0);
    chk("z flush occupancy", {126'b0, occz}, 128'd0);
    chk("z stall_cnt", {124'b0, stz}, 128'd2);
    drive0(1, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("z drained out_valid", {127'b0, ovz}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
